// File: rtl/ltsm_sb_msg_arbiter.sv
// Round-robin owner of the shared LTSM sideband message path: latch, issue, wait for consume.
// Optional WAIT watchdog enabled by defining LTSM_SB_ARB_TIMEOUT_EN.
module ltsm_sb_msg_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int MSG_W       = 4,
    parameter int TIMEOUT_CYC = 8000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_en,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*MSG_W-1:0] i_req_msg,
    input  logic                     i_busy,
    input  logic                     i_falling_edge_busy,
    output logic [MSG_W-1:0]         o_sideband_message,
    output logic                     o_valid,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic [NUM_REQ-1:0]       o_done,
    output logic                     o_timeout
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] win;
    logic [PW-1:0] gidx_next;
    logic          found;

`ifdef LTSM_SB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic [TW-1:0] cnt;
`endif

    // Descending scan so the smallest offset from rr_ptr is the last write and wins.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (i_req_valid[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign gidx_next = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            gidx               <= '0;
            o_sideband_message <= '0;
            o_valid            <= 1'b0;
            o_grant            <= '0;
            o_done             <= '0;
            o_timeout          <= 1'b0;
`ifdef LTSM_SB_ARB_TIMEOUT_EN
            cnt                <= '0;
`endif
        end else begin
            o_valid   <= 1'b0;
            o_done    <= '0;
            o_timeout <= 1'b0;
            if (!i_en) begin
                // Abort drops the transfer silently; rr_ptr keeps the owner first in line.
                state              <= IDLE;
                o_grant            <= '0;
                o_sideband_message <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!i_busy && found) begin
                            o_sideband_message <= i_req_msg[win*MSG_W +: MSG_W];
                            o_grant            <= NUM_REQ'(1) << win;
                            gidx               <= win;
                            o_valid            <= 1'b1;
                            state              <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        // A falling edge here belongs to an earlier transfer.
                        state <= WAIT;
`ifdef LTSM_SB_ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                    WAIT: begin
                        if (i_falling_edge_busy) begin
                            o_done  <= NUM_REQ'(1) << gidx;
                            o_grant <= '0;
                            rr_ptr  <= gidx_next;
                            state   <= IDLE;
                        end
`ifdef LTSM_SB_ARB_TIMEOUT_EN
                        else if (cnt == TW'(TIMEOUT_CYC - 1)) begin
                            o_timeout <= 1'b1;
                            o_grant   <= '0;
                            rr_ptr    <= gidx_next;
                            state     <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
